// File: rtl/prio_decoder_hold.sv
// prio_decoder_hold: 3-bit priority code to one-hot decoder
// that holds each decoded line for HOLD cycles, with a sticky error flag.
module prio_decoder_hold #(
   parameter int unsigned HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] y,
   input  logic       y_valid,
   output logic       y_ready,
   input  logic       err_clr,
   output logic [4:1] r,
   output logic       busy,
   output logic       done_tick,
   output logic       err
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   localparam logic [7:0] LOAD = 8'(HOLD - 1);

   logic       state;
   logic [7:0] cnt;
   logic       xfer;
   logic       legal;
   logic       illegal;
   logic [4:1] dec;

   assign y_ready = (state == ST_IDLE);
   assign busy    = (state == ST_HOLD);
   assign xfer    = y_valid && y_ready;

   // Map the code to its one-hot line and classify it.
   always_comb begin
      dec     = 4'b0000;
      legal   = 1'b0;
      illegal = 1'b0;
      unique case (y)
         3'b000: ;
         3'b001: begin dec = 4'b0001; legal = 1'b1; end
         3'b010: begin dec = 4'b0010; legal = 1'b1; end
         3'b011: begin dec = 4'b0100; legal = 1'b1; end
         3'b100: begin dec = 4'b1000; legal = 1'b1; end
         default: illegal = 1'b1;
      endcase
   end

   // Hold FSM: load on a legal transfer, count down, release with a tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         r         <= 4'b0000;
         cnt       <= 8'd0;
         done_tick <= 1'b0;
      end else begin
         done_tick <= 1'b0;
         if (state == ST_IDLE) begin
            if (xfer && legal) begin
               r     <= dec;
               cnt   <= LOAD;
               state <= ST_HOLD;
            end
         end else begin
            if (cnt == 8'd0) begin
               r         <= 4'b0000;
               state     <= ST_IDLE;
               done_tick <= 1'b1;
            end else begin
               cnt <= cnt - 8'd1;
            end
         end
      end
   end

   // Sticky error: an accepted illegal code beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else if (xfer && illegal) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prio_decoder_hold.sv
// tb_prio_decoder_hold: directed checks of the hold decoder,
// HOLD=4 main instance plus a HOLD=1 instance sharing the inputs.
module tb_prio_decoder_hold;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] y = 3'b000;
   logic       y_valid = 1'b0;
   logic       err_clr = 1'b0;

   logic       y_ready, busy, done_tick, err;
   logic [4:1] r;
   logic       y_ready1, busy1, done_tick1, err1;
   logic [4:1] r1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_decoder_hold #(.HOLD(4)) dut (
      .clk(clk), .reset(reset), .y(y), .y_valid(y_valid),
      .y_ready(y_ready), .err_clr(err_clr), .r(r), .busy(busy),
      .done_tick(done_tick), .err(err)
   );

   prio_decoder_hold #(.HOLD(1)) dut1 (
      .clk(clk), .reset(reset), .y(y), .y_valid(y_valid),
      .y_ready(y_ready1), .err_clr(err_clr), .r(r1), .busy(busy1),
      .done_tick(done_tick1), .err(err1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; y_valid = 1'b0; err_clr = 1'b0; y = 3'b000;
      step(); step();
      reset = 1'b0;
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", y_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL reset_r got %b want 0000", r); end
      checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_tick); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
   endtask

   task automatic test_hold4();
      y = 3'b011; y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (r !== 4'b0100) begin errors++; $display("FAIL hold_r[%0d] got %b want 0100", i, r); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d] got %b want 1", i, busy); end
         checks++; if (y_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, y_ready); end
         checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL hold_done[%0d] got %b want 0", i, done_tick); end
         step();
      end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL hold_end_r got %b want 0000", r); end
      checks++; if (done_tick !== 1'b1) begin errors++; $display("FAIL hold_end_done got %b want 1", done_tick); end
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL hold_end_ready got %b want 1", y_ready); end
      step();
      checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL hold_done_pulse got %b want 0", done_tick); end
   endtask

   task automatic test_back_to_back();
      y = 3'b100; y_valid = 1'b1;
      step();
      y = 3'b001;
      for (int i = 0; i < 4; i++) begin
         checks++; if (r !== 4'b1000) begin errors++; $display("FAIL b2b_first_r[%0d] got %b want 1000", i, r); end
         step();
      end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL b2b_gap_r got %b want 0000", r); end
      checks++; if (done_tick !== 1'b1) begin errors++; $display("FAIL b2b_gap_done got %b want 1", done_tick); end
      step();
      y_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (r !== 4'b0001) begin errors++; $display("FAIL b2b_second_r[%0d] got %b want 0001", i, r); end
         checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL b2b_second_done[%0d] got %b want 0", i, done_tick); end
         step();
      end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL b2b_end_r got %b want 0000", r); end
      checks++; if (done_tick !== 1'b1) begin errors++; $display("FAIL b2b_end_done got %b want 1", done_tick); end
      step();
   endtask

   task automatic test_err();
      y = 3'b110; y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL err_r got %b want 0000", r); end
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", y_ready); end
      step();
      checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL err_done got %b want 0", done_tick); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      y = 3'b111; y_valid = 1'b1; err_clr = 1'b1;
      step();
      y_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", err); end
      step();
      err_clr = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL err_clear_r got %b want 0000", r); end
   endtask

   task automatic test_zero();
      y = 3'b000; y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL zero_r got %b want 0000", r); end
      checks++; if (y_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", y_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", err); end
      step();
      checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL zero_done got %b want 0", done_tick); end
   endtask

   task automatic test_reset_abort();
      y = 3'b010; y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      checks++; if (r !== 4'b0010) begin errors++; $display("FAIL abort_r got %b want 0010", r); end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL abort_r_clr got %b want 0000", r); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL abort_done[%0d] got %b want 0", i, done_tick); end
         step();
      end
   endtask

   task automatic test_hold1();
      reset = 1'b1;
      step();
      reset = 1'b0;
      y = 3'b001; y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      checks++; if (r1 !== 4'b0001) begin errors++; $display("FAIL h1_r got %b want 0001", r1); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL h1_busy got %b want 1", busy1); end
      step();
      checks++; if (r1 !== 4'b0000) begin errors++; $display("FAIL h1_r_end got %b want 0000", r1); end
      checks++; if (done_tick1 !== 1'b1) begin errors++; $display("FAIL h1_done got %b want 1", done_tick1); end
      step();
      checks++; if (done_tick1 !== 1'b0) begin errors++; $display("FAIL h1_done_pulse got %b want 0", done_tick1); end
   endtask

   initial begin
      test_reset();
      test_hold4();
      test_back_to_back();
      test_err();
      test_zero();
      test_reset_abort();
      test_hold1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prio_decoder_hold.md
PRIO_DECODER_HOLD -- requirements
Module: prio_decoder_hold

Interface
REQ-001: Parameter HOLD, default 4, number of clock cycles a decoded one-hot output stays asserted; legal range 1..255.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: y  input  3  priority code: 3'b100..3'b001 select lines 4..1, 3'b000 means no request.
REQ-005: y_valid  input  1  code on y is offered this cycle.
REQ-006: y_ready  output  1  block can accept a code this cycle.
REQ-007: err_clr  input  1  clears the sticky error flag.
REQ-008: r  output  4 ([4:1])  registered one-hot decoded request lines.
REQ-009: busy  output  1  high while a decoded line is being held.
REQ-010: done_tick  output  1  one-cycle pulse at end of a hold interval.
REQ-011: err  output  1  sticky flag: illegal code (3'b101..3'b111) was accepted.

Function
REQ-012: The block SHALL use a two-state FSM: IDLE and HOLD.
REQ-013: y_ready SHALL be combinational and equal to (state == IDLE); busy SHALL equal (state == HOLD).
REQ-014: Transfer occurs on a rising edge where y_valid && y_ready; y is ignored at all other edges.
REQ-015: Transfer of a code 3'b001..3'b100 SHALL, at that edge, load r with the matching one-hot value (001->0001, 010->0010, 011->0100, 100->1000), load an 8-bit counter with HOLD-1, and enter HOLD.
REQ-016: Transfer of 3'b000 SHALL leave r = 4'b0000, remain in IDLE, and produce no done_tick.
REQ-017: Transfer of 3'b101..3'b111 SHALL leave r = 4'b0000, remain in IDLE, set err, and produce no done_tick.
REQ-018: In HOLD, r SHALL remain constant; the counter SHALL decrement by 1 each edge while nonzero.
REQ-019: In HOLD with counter == 0, the next edge SHALL clear r to 4'b0000, return to IDLE, and assert done_tick for exactly that following cycle.
REQ-020: r SHALL therefore be nonzero for exactly HOLD consecutive cycles per legal nonzero code; HOLD=1 yields a single-cycle assertion.
REQ-021: done_tick SHALL be registered and high only in the first IDLE cycle after a HOLD interval.
REQ-022: A new transfer is permitted in the cycle done_tick is high; back-to-back codes SHALL therefore show exactly one cycle of r = 4'b0000 between hold intervals.
REQ-023: err SHALL remain set until an edge with err_clr = 1; if err_clr coincides with an illegal-code transfer, err SHALL be 1 after that edge (set wins).
REQ-024: err_clr SHALL have no effect on r, state, or counter.
REQ-025: At most one bit of r SHALL be 1 in any cycle.

Reset
REQ-026: On an edge with reset = 1, state SHALL become IDLE, r = 4'b0000, counter = 0, done_tick = 0, err = 0, taking priority over all other inputs.
REQ-027: Reset asserted during HOLD SHALL abort the interval with no done_tick after reset deasserts.
REQ-028: Outputs after reset: y_ready = 1, busy = 0, r = 0, done_tick = 0, err = 0.

Verification (HOLD = 4 unless stated)
REQ-029: Reset, then y=3'b011, y_valid=1 one cycle -> r=4'b0100 for 4 cycles, busy=1 same 4 cycles, y_ready=0 during them, then r=0, done_tick=1 one cycle.
REQ-030: y_valid held high with y=3'b100 then 3'b001 -> r=1000 for 4 cycles, one cycle r=0 with done_tick=1 and transfer of 001, then r=0001 for 4 cycles; code changes while busy are ignored.
REQ-031: y=3'b110 transferred -> err=1, r stays 0, no done_tick; then err_clr=1 with y=3'b111 transferred same edge -> err stays 1; err_clr alone -> err=0.
REQ-032: y=3'b000 transferred -> r=0, y_ready stays 1, no done_tick, err stays 0.
REQ-033: y=3'b010 transferred, reset asserted on second HOLD cycle -> r=0, busy=0, no done_tick in any later cycle until a new transfer.
REQ-034: HOLD=1 instance, y=3'b001 transferred -> r=0001 exactly one cycle, done_tick next cycle.
